bcd_seg_scan: RTL and testbench
===============================

BCD_SEG_SCAN -- requirements
Module: bcd_seg_scan

Interface
REQ-001 The block SHALL have parameter TICKS, default 50000, giving clock cycles per digit slot; legal values are at least 2.
REQ-002 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 load  input  1  one-cycle strobe; SHALL capture hundreds/tens/ones on the same edge.
REQ-005 hundreds  input  4  BCD hundreds digit.
REQ-006 tens  input  4  BCD tens digit.
REQ-007 ones  input  4  BCD ones digit.
REQ-008 blank_lz  input  1  leading-zero blanking enable, sampled every cycle.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-low, registered.
REQ-010 an  output  3  digit enables {hund,tens,ones}, active-low, registered.
REQ-011 load_ack  output  1  one-cycle pulse when captured digits become the displayed digits.

Function
REQ-012 A prescaler SHALL count 0..TICKS-1 and wrap to 0; the wrap cycle is the "tick".
REQ-013 The scan FSM SHALL have states ONES -> TENS -> HUND -> ONES and advance only on a tick.
REQ-014 Each digit SHALL be displayed for exactly TICKS cycles; one frame SHALL be 3*TICKS cycles.
REQ-015 The frame boundary SHALL be the tick taken in state HUND.
REQ-016 Double buffering: load SHALL write a shadow register set and set pending; any later load before the boundary SHALL overwrite the shadow values.
REQ-017 At the frame boundary with pending set, the shadow values SHALL copy to the active set, pending SHALL clear, and load_ack SHALL pulse on the following cycle.
REQ-018 If load coincides with the frame boundary, the load values SHALL go directly to active, and load_ack SHALL pulse on the next cycle.
REQ-019 Multiple loads within one frame SHALL produce exactly one load_ack.
REQ-020 an SHALL be registered from the FSM state: ONES=3'b110, TENS=3'b101, HUND=3'b011, so an lags the state by one cycle.
REQ-021 seg SHALL encode the active digit of the current state: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 An active digit greater than 9 SHALL display a dash (0111111) and SHALL never be blanked.
REQ-023 With blank_lz=1, the hundreds digit SHALL be blank (1111111) when it is 0.
REQ-024 With blank_lz=1, the tens digit SHALL be blank when both hundreds and tens are 0.
REQ-025 The ones digit SHALL never be blanked; with blank_lz=0, no digit SHALL be blanked.
REQ-026 Only a single an bit SHALL be low in any cycle after reset.

Reset
REQ-027 While rst_n=0: seg=7'b1111111, an=3'b111, load_ack=0, prescaler=0, state=ONES, active and shadow digits=0, pending=0.
REQ-028 Assertion of rst_n mid-frame or with pending set SHALL discard pending data, and no load_ack SHALL follow.
REQ-029 On the first rising edge after rst_n rises, an SHALL be 3'b110 and seg SHALL be 1000000 (active ones=0).

Verification (TICKS=4)
REQ-030 Reset release, no load, blank_lz=0 -> an cycles 110 x4, 101 x4, 011 x4, repeating; seg stays 1000000 throughout.
REQ-031 load 1/2/3 mid-frame -> display unchanged until the boundary; then ones=0110000, tens=0100100, hund=1111001; load_ack is high exactly one cycle.
REQ-032 load 0/0/7 with blank_lz=1 -> hund and tens slots show 1111111, ones shows 1111000; with blank_lz=0, 1000000/1000000/1111000.
REQ-033 loads 4/5/6 then 8/8/8 within one frame -> a single load_ack; the next frame shows 0000000 in all slots; 4/5/6 is never displayed.
REQ-034 load 0/12/5 (tens invalid) with blank_lz=1 -> hund blank, tens 0111111, ones 0010010.
REQ-035 load 9/9/9, rst_n pulsed low before the boundary -> outputs at reset values, no load_ack; after release, all slots show 1000000.

Source files
------------

// File: rtl/bcd_seg_scan.sv
// Three-digit multiplexed 7-segment driver with double-buffered BCD digits.
// Digits are scanned ones -> tens -> hundreds, TICKS clock cycles per slot.
module bcd_seg_scan #(
  parameter int unsigned TICKS = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] hundreds,
  input  logic [3:0] tens,
  input  logic [3:0] ones,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [2:0] an,
  output logic       load_ack
);

  localparam int unsigned CW = (TICKS > 2) ? $clog2(TICKS) : 1;
  localparam int unsigned DW = 4;
  localparam int unsigned SW = 7;

  localparam logic [SW-1:0] SEG_BLANK = 7'b1111111;
  localparam logic [SW-1:0] SEG_DASH  = 7'b0111111;
  localparam logic [2:0]    AN_OFF    = 3'b111;
  localparam logic [2:0]    AN_ONES   = 3'b110;
  localparam logic [2:0]    AN_TENS   = 3'b101;
  localparam logic [2:0]    AN_HUND   = 3'b011;

  typedef enum logic [1:0] {
    ONES = 2'd0,
    TENS = 2'd1,
    HUND = 2'd2
  } state_t;

  state_t        state;
  logic [CW-1:0] presc;

  logic [DW-1:0] act_h, act_t, act_o;
  logic [DW-1:0] sh_h, sh_t, sh_o;
  logic          pending;

  logic          tick_c;
  logic          boundary_c;
  logic [DW-1:0] cur_digit_c;
  logic          blank_c;
  logic [SW-1:0] glyph_c;
  logic [2:0]    an_c;

  // Slot prescaler: the wrap cycle is the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
    end else if (tick_c) begin
      presc <= '0;
    end else begin
      presc <= presc + CW'(1);
    end
  end

  assign tick_c     = (presc == CW'(TICKS - 1));
  assign boundary_c = tick_c && (state == HUND);

  // Scan FSM; advances one digit slot per tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ONES;
    end else if (tick_c) begin
      unique case (state)
        ONES:    state <= TENS;
        TENS:    state <= HUND;
        HUND:    state <= ONES;
        default: state <= ONES;
      endcase
    end
  end

  // Double buffer: loads land in the shadow set and are promoted only at a
  // frame boundary; a load on the boundary itself bypasses the shadow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_h    <= '0;
      act_t    <= '0;
      act_o    <= '0;
      sh_h     <= '0;
      sh_t     <= '0;
      sh_o     <= '0;
      pending  <= 1'b0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= boundary_c && (load || pending);
      if (boundary_c) begin
        pending <= 1'b0;
        if (load) begin
          act_h <= hundreds;
          act_t <= tens;
          act_o <= ones;
        end else if (pending) begin
          act_h <= sh_h;
          act_t <= sh_t;
          act_o <= sh_o;
        end
      end else if (load) begin
        sh_h    <= hundreds;
        sh_t    <= tens;
        sh_o    <= ones;
        pending <= 1'b1;
      end
    end
  end

  function automatic logic [SW-1:0] seg_decode(input logic [DW-1:0] d);
    logic [SW-1:0] s;
    unique case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_DASH;
    endcase
    return s;
  endfunction

  // Digit select and leading-zero blanking; invalid digits are never zero,
  // so they can never be blanked.
  always_comb begin
    cur_digit_c = act_o;
    blank_c     = 1'b0;
    an_c        = AN_OFF;
    unique case (state)
      ONES: begin
        cur_digit_c = act_o;
        an_c        = AN_ONES;
      end
      TENS: begin
        cur_digit_c = act_t;
        blank_c     = blank_lz && (act_h == '0) && (act_t == '0);
        an_c        = AN_TENS;
      end
      HUND: begin
        cur_digit_c = act_h;
        blank_c     = blank_lz && (act_h == '0);
        an_c        = AN_HUND;
      end
      default: begin
        cur_digit_c = act_o;
        an_c        = AN_OFF;
      end
    endcase
    glyph_c = blank_c ? SEG_BLANK : seg_decode(cur_digit_c);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg <= SEG_BLANK;
      an  <= AN_OFF;
    end else begin
      seg <= glyph_c;
      an  <= an_c;
    end
  end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Scoreboard bench for bcd_seg_scan: driver pushes expected outputs from a
// frame-arithmetic reference model; a monitor pops and compares each cycle.
module tb_bcd_seg_scan;

  localparam int unsigned T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load = 1'b0;
  logic [3:0] hundreds = '0;
  logic [3:0] tens = '0;
  logic [3:0] ones = '0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic [2:0] an;
  logic       load_ack;

  bcd_seg_scan #(.TICKS(T)) dut (
    .clk(clk), .rst_n(rst_n), .load(load),
    .hundreds(hundreds), .tens(tens), .ones(ones),
    .blank_lz(blank_lz), .seg(seg), .an(an), .load_ack(load_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic [2:0] an;
    logic       ack;
    int         cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;

  // Reference model: c counts edges since reset release; the slot and
  // frame boundary follow from integer division of c.
  int   c = 0;
  int   act[3];   // [0]=ones [1]=tens [2]=hundreds
  int   sh[3];
  bit   pend = 1'b0;

  logic [6:0] glyphs [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000};
  logic [2:0] an_codes [3] = '{3'b110, 3'b101, 3'b011};

  function automatic logic [6:0] model_seg(input int slot, input bit bl);
    int d;
    d = act[slot];
    if (d > 9) return 7'b0111111;
    if (bl && slot == 2 && act[2] == 0) return 7'b1111111;
    if (bl && slot == 1 && act[2] == 0 && act[1] == 0) return 7'b1111111;
    return glyphs[d];
  endfunction

  task automatic step(input bit r, input bit ld, input int h, input int t,
                      input int o, input bit bl);
    exp_t e;
    int   slot;
    bit   bnd;
    @(negedge clk);
    rst_n = r; load = ld; blank_lz = bl;
    hundreds = 4'(h); tens = 4'(t); ones = 4'(o);
    cyc++;
    e.cyc = cyc;
    if (!r) begin
      e.seg = 7'b1111111; e.an = 3'b111; e.ack = 1'b0;
      c = 0; pend = 1'b0;
      for (int i = 0; i < 3; i++) begin act[i] = 0; sh[i] = 0; end
    end else begin
      slot  = (c / T) % 3;
      bnd   = (c % (3 * T)) == (3 * T - 1);
      e.an  = an_codes[slot];
      e.seg = model_seg(slot, bl);
      e.ack = bnd && (ld || pend);
      if (bnd) begin
        if (ld) begin act[0] = o; act[1] = t; act[2] = h; end
        else if (pend) act = sh;
        pend = 1'b0;
      end else if (ld) begin
        sh[0] = o; sh[1] = t; sh[2] = h; pend = 1'b1;
      end
      c++;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n, input bit bl);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, 0, bl);
  endtask

  task automatic to_phase(input int ph, input bit bl);
    while ((c % (3 * T)) != ph) step(1'b1, 1'b0, 0, 0, 0, bl);
  endtask

  // Monitor: compares DUT outputs against the oldest expectation.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if (seg === e.seg) passes++;
      else $display("FAIL seg cyc=%0d got=%b want=%b", e.cyc, seg, e.seg);
      checks++;
      if (an === e.an) passes++;
      else $display("FAIL an cyc=%0d got=%b want=%b", e.cyc, an, e.an);
      checks++;
      if (load_ack === e.ack) passes++;
      else $display("FAIL load_ack cyc=%0d got=%b want=%b", e.cyc, load_ack, e.ack);
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) begin act[i] = 0; sh[i] = 0; end
    repeat (3) step(1'b0, 1'b0, 0, 0, 0, 1'b0);
    // Idle scan after reset release
    idle(26, 1'b0);
    // Mid-frame load of 1/2/3
    to_phase(5, 1'b0);
    step(1'b1, 1'b1, 1, 2, 3, 1'b0);
    idle(28, 1'b0);
    // Leading-zero blanking on and off
    to_phase(2, 1'b1);
    step(1'b1, 1'b1, 0, 0, 7, 1'b1);
    idle(24, 1'b1);
    idle(12, 1'b0);
    // Two loads in one frame
    to_phase(1, 1'b0);
    step(1'b1, 1'b1, 4, 5, 6, 1'b0);
    idle(3, 1'b0);
    step(1'b1, 1'b1, 8, 8, 8, 1'b0);
    idle(26, 1'b0);
    // Invalid tens digit
    to_phase(3, 1'b1);
    step(1'b1, 1'b1, 0, 12, 5, 1'b1);
    idle(26, 1'b1);
    // Load coinciding with the frame boundary, also after a pending load
    to_phase(3 * T - 1, 1'b0);
    step(1'b1, 1'b1, 2, 0, 9, 1'b0);
    idle(14, 1'b0);
    step(1'b1, 1'b1, 3, 3, 3, 1'b0);
    to_phase(3 * T - 1, 1'b0);
    step(1'b1, 1'b1, 6, 7, 1, 1'b0);
    idle(14, 1'b0);
    // Reset with a pending load discards it
    to_phase(1, 1'b0);
    step(1'b1, 1'b1, 9, 9, 9, 1'b0);
    idle(2, 1'b0);
    repeat (2) step(1'b0, 1'b0, 0, 0, 0, 1'b0);
    idle(30, 1'b0);
    // Randomized traffic
    for (int i = 0; i < 2500; i++) begin
      bit r, ld, bl;
      r  = ($urandom_range(0, 199) != 0);
      ld = ($urandom_range(0, 7) == 0);
      bl = ($urandom_range(0, 3) != 0);
      step(r, ld, $urandom_range(0, 15) % 12, $urandom_range(0, 11),
           $urandom_range(0, 10), bl);
    end
    idle(2, 1'b0);
    repeat (2) @(negedge clk);
    checks++;
    if (q.size() == 0) passes++;
    else $display("FAIL drain got=%0d want=0 pending expectations", q.size());
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
